// File: rtl/shot_avg_acc.sv
// rtl/shot_avg_acc.sv - per-slot shot-summing accumulator with saturating read-modify-write pipeline
module shot_avg_acc #(
   parameter int DATAWIDTH    = 32,
   parameter int SUMWIDTH     = 48,
   parameter int ADDRWIDTH    = 10,
   parameter int SHOTCNTWIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [SHOTCNTWIDTH-1:0] nshots,
   input  logic                    shot_end,
   input  logic                    in_valid,
   input  logic [DATAWIDTH-1:0]    in_x,
   input  logic [DATAWIDTH-1:0]    in_y,
   input  logic                    rd_en,
   input  logic [ADDRWIDTH-1:0]    rd_addr,
   output logic                    rd_valid,
   output logic [SUMWIDTH-1:0]     rd_x,
   output logic [SUMWIDTH-1:0]     rd_y,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [ADDRWIDTH:0]      meas_count
);
   localparam int NSLOTS = 1 << ADDRWIDTH;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t                   state;
   logic [SHOTCNTWIDTH-1:0]  nshots_r, shotcnt;
   logic [ADDRWIDTH:0]       idx;
   logic [ADDRWIDTH-1:0]     clr_idx;
   logic                     drain;

   logic [SUMWIDTH-1:0]        mem_x [NSLOTS];
   logic [SUMWIDTH-1:0]        mem_y [NSLOTS];
   logic signed [SUMWIDTH-1:0] mem_rd_x, mem_rd_y;
   logic [ADDRWIDTH-1:0]       mem_raddr;

   logic                        s1_valid, s2_valid, w_valid;
   logic [ADDRWIDTH-1:0]        s1_addr, s2_addr, w_addr;
   logic signed [DATAWIDTH-1:0] s1_x, s1_y, s2_x, s2_y;
   logic signed [SUMWIDTH-1:0]  s2_base_x, s2_base_y, w_x, w_y;
   logic signed [SUMWIDTH-1:0]  fwd_x, fwd_y;
   logic [SUMWIDTH:0]           sx, sy;
   logic                        live, accept, take;

   // Returns {saturated, sum}; saturation clamps toward the sign of the true result.
   function automatic logic [SUMWIDTH:0] sat_add(input logic signed [SUMWIDTH-1:0] base,
                                                 input logic signed [DATAWIDTH-1:0] din);
      logic signed [SUMWIDTH:0] full;
      full = (SUMWIDTH+1)'(base) + (SUMWIDTH+1)'(din);
      if (full[SUMWIDTH] != full[SUMWIDTH-1])
         return {1'b1, full[SUMWIDTH], {(SUMWIDTH-1){~full[SUMWIDTH]}}};
      return {1'b0, full[SUMWIDTH-1:0]};
   endfunction

   always_comb begin
      live      = (state == RUN) && (shotcnt != nshots_r);
      accept    = live && in_valid;
      take      = accept && !idx[ADDRWIDTH];
      mem_raddr = (state == RUN) ? idx[ADDRWIDTH-1:0] : rd_addr;
      sx        = sat_add(s2_base_x, s2_x);
      sy        = sat_add(s2_base_y, s2_y);
      // Read data misses the write in S2 and the one retired on the read edge.
      fwd_x = mem_rd_x;
      fwd_y = mem_rd_y;
      if (s2_valid && s2_addr == s1_addr) begin
         fwd_x = sx[SUMWIDTH-1:0];
         fwd_y = sy[SUMWIDTH-1:0];
      end else if (w_valid && w_addr == s1_addr) begin
         fwd_x = w_x;
         fwd_y = w_y;
      end
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem_x[clr_idx] <= '0;
         mem_y[clr_idx] <= '0;
      end else if (s2_valid) begin
         mem_x[s2_addr] <= sx[SUMWIDTH-1:0];
         mem_y[s2_addr] <= sy[SUMWIDTH-1:0];
      end
      mem_rd_x <= mem_x[mem_raddr];
      mem_rd_y <= mem_y[mem_raddr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         nshots_r   <= '0;
         shotcnt    <= '0;
         idx        <= '0;
         clr_idx    <= '0;
         drain      <= 1'b0;
         overflow   <= 1'b0;
         meas_count <= '0;
         rd_valid   <= 1'b0;
         s1_valid   <= 1'b0;
         s1_addr    <= '0;
         s1_x       <= '0;
         s1_y       <= '0;
         s2_valid   <= 1'b0;
         s2_addr    <= '0;
         s2_x       <= '0;
         s2_y       <= '0;
         s2_base_x  <= '0;
         s2_base_y  <= '0;
         w_valid    <= 1'b0;
         w_addr     <= '0;
         w_x        <= '0;
         w_y        <= '0;
      end else begin
         rd_valid  <= rd_en && (state == IDLE || state == DONE);
         s1_valid  <= take;
         s1_addr   <= idx[ADDRWIDTH-1:0];
         s1_x      <= in_x;
         s1_y      <= in_y;
         s2_valid  <= s1_valid;
         s2_addr   <= s1_addr;
         s2_x      <= s1_x;
         s2_y      <= s1_y;
         s2_base_x <= fwd_x;
         s2_base_y <= fwd_y;
         w_valid   <= s2_valid;
         w_addr    <= s2_addr;
         w_x       <= sx[SUMWIDTH-1:0];
         w_y       <= sy[SUMWIDTH-1:0];
         if (s2_valid && (sx[SUMWIDTH] || sy[SUMWIDTH]))
            overflow <= 1'b1;
         if (start) begin
            state    <= CLEAR;
            nshots_r <= nshots;
            shotcnt  <= '0;
            idx      <= '0;
            clr_idx  <= '0;
            drain    <= 1'b0;
            overflow <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_valid  <= 1'b0;
         end else begin
            case (state)
               CLEAR: begin
                  clr_idx <= clr_idx + ADDRWIDTH'(1);
                  if (clr_idx == ADDRWIDTH'(NSLOTS - 1))
                     state <= (nshots_r == '0) ? DONE : RUN;
               end
               RUN: begin
                  if (accept) begin
                     if (idx[ADDRWIDTH])
                        overflow <= 1'b1;
                     else
                        idx <= idx + (ADDRWIDTH+1)'(1);
                  end
                  if (live && shot_end) begin
                     shotcnt    <= shotcnt + SHOTCNTWIDTH'(1);
                     meas_count <= idx + (ADDRWIDTH+1)'(take);
                     idx        <= '0;
                     drain      <= 1'b1;
                  end else if (!live) begin
                     // One extra cycle lets the final sample retire from S2.
                     if (drain)
                        drain <= 1'b0;
                     else
                        state <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy = (state == CLEAR) || (state == RUN);
   assign done = (state == DONE);
   assign rd_x = rd_valid ? mem_rd_x : '0;
   assign rd_y = rd_valid ? mem_rd_y : '0;
endmodule

// File: tb/tb_shot_avg_acc.sv
// tb/tb_shot_avg_acc.sv - randomized and directed bench for shot_avg_acc against a sum model
module tb_shot_avg_acc;
   localparam int DW = 32;
   localparam int SW = 34;
   localparam int AW = 10;
   localparam int CW = 16;
   localparam int NS = 1 << AW;
   localparam longint SMAX = (64'sd1 <<< (SW - 1)) - 1;
   localparam longint SMIN = -(64'sd1 <<< (SW - 1));

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] nshots = '0;
   logic          shot_end = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_x = '0;
   logic [DW-1:0] in_y = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_valid;
   logic [SW-1:0] rd_x, rd_y;
   logic          busy, done, overflow;
   logic [AW:0]   meas_count;

   always #5 clk = ~clk;

   shot_avg_acc #(.DATAWIDTH(DW), .SUMWIDTH(SW), .ADDRWIDTH(AW), .SHOTCNTWIDTH(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .nshots(nshots), .shot_end(shot_end),
      .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .busy(busy), .done(done),
      .overflow(overflow), .meas_count(meas_count)
   );

   int nchecks = 0;
   int nerrors = 0;

   longint mx [NS];
   longint my [NS];
   int     m_idx, m_shots, m_n, m_meas;
   bit     m_ovf;

   task automatic check(input string tag, input longint got, input longint exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input longint a, input longint b);
      longint s;
      s = a + b;
      if (s > SMAX) begin m_ovf = 1'b1; return SMAX; end
      if (s < SMIN) begin m_ovf = 1'b1; return SMIN; end
      return s;
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_run(input int n);
      start = 1'b1;
      nshots = CW'(n);
      cycle();
      start = 1'b0;
      for (int i = 0; i < NS; i++) begin mx[i] = 0; my[i] = 0; end
      m_idx = 0; m_shots = 0; m_n = n; m_ovf = 1'b0;
      repeat (NS + 1) cycle();
   endtask

   task automatic send(input bit v, input longint x, input longint y, input bit se);
      in_valid = v; in_x = x[DW-1:0]; in_y = y[DW-1:0]; shot_end = se;
      cycle();
      in_valid = 1'b0; shot_end = 1'b0;
      if (m_shots < m_n) begin
         if (v) begin
            if (m_idx < NS) begin
               mx[m_idx] = sat(mx[m_idx], x);
               my[m_idx] = sat(my[m_idx], y);
               m_idx++;
            end else m_ovf = 1'b1;
         end
         if (se) begin m_meas = m_idx; m_idx = 0; m_shots++; end
      end
   endtask

   task automatic wait_done(input string tag);
      int cnt;
      cnt = 1;
      while (!done && cnt < 20) begin cycle(); cnt++; end
      check(tag, cnt, 3);
   endtask

   task automatic read_check(input string tag, input int a, input longint ex, input longint ey);
      rd_en = 1'b1; rd_addr = AW'(a);
      cycle();
      rd_en = 1'b0;
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_x"}, $signed(rd_x), ex);
      check({tag, "_y"}, $signed(rd_y), ey);
   endtask

   task automatic check_model(input string tag, input int nslots);
      check({tag, "_meas"}, meas_count, m_meas);
      check({tag, "_ovf"}, overflow, m_ovf);
      for (int i = 0; i < nslots; i++) read_check(tag, i, mx[i], my[i]);
   endtask

   initial begin
      cycle();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_rdv", rd_valid, 0);
      check("rst_meas", meas_count, 0);
      reset = 1'b1;
      cycle();

      // basic 4-shot sum
      start_run(4);
      check("t1_busy", busy, 1);
      for (int s = 0; s < 4; s++) begin
         send(1, 10, 1, 0);
         send(1, -20, 2, 0);
         send(1, 30, 3, 0);
         send(0, 0, 0, 1);
      end
      wait_done("t1_done_lat");
      read_check("t1_s0", 0, 40, 4);
      read_check("t1_s1", 1, -80, 8);
      read_check("t1_s2", 2, 120, 12);
      check("t1_meas", meas_count, 3);
      check("t1_ovf", overflow, 0);

      // one slot per shot, valid and shot_end together
      start_run(5);
      repeat (5) send(1, 7, -3, 1);
      wait_done("t2_done_lat");
      read_check("t2_s0", 0, 35, -15);
      read_check("t2_s1", 1, 0, 0);

      // saturation in both directions
      start_run(8);
      repeat (8) send(1, 64'sh7FFF_FFFF, -64'sd2147483648, 1);
      wait_done("t3_done_lat");
      read_check("t3_s0", 0, SMAX, SMIN);
      check("t3_ovf", overflow, 1);

      // slot overrun
      start_run(1);
      for (int i = 0; i <= NS; i++) send(1, i + 1, -(i + 1), 0);
      send(0, 0, 0, 1);
      wait_done("t4_done_lat");
      check("t4_meas", meas_count, NS);
      check("t4_ovf", overflow, 1);
      read_check("t4_s1023", NS - 1, NS, -NS);
      read_check("t4_s0", 0, 1, -1);

      // restart mid-run clears sums and overflow
      start_run(4);
      repeat (NS + 1) send(1, 3, 3, 0);
      send(0, 0, 0, 1);
      send(1, 9, 9, 0);
      send(1, 9, 9, 1);
      check("t5_ovf_before", overflow, 1);
      start_run(1);
      check("t5_ovf_cleared", overflow, 0);
      send(1, 5, 6, 1);
      wait_done("t5_done_lat");
      read_check("t5_s0", 0, 5, 6);
      read_check("t5_s1", 1, 0, 0);
      read_check("t5_s2", 2, 0, 0);
      read_check("t5_s1023", NS - 1, 0, 0);
      check("t5_ovf", overflow, 0);
      check("t5_meas", meas_count, 1);

      // randomized runs against the model
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 6);
         start_run(n);
         for (int s = 0; s < n; s++) begin
            int k;
            k = $urandom_range(0, 8);
            for (int j = 0; j < k; j++) begin
               longint x, y;
               if ($urandom_range(0, 1) == 1)
                  x = ($urandom_range(0, 1) == 1) ? 64'sd2147483647 : -64'sd2147483648;
               else
                  x = longint'($signed($urandom));
               y = longint'($signed($urandom));
               if ($urandom_range(0, 3) == 0) send(0, 0, 0, 0);
               send(1, x, y, (j == k - 1) && ($urandom_range(0, 1) == 1));
            end
            if (m_shots == s) send(0, 0, 0, 1);
         end
         wait_done("rnd_done_lat");
         check_model("rnd", 9);
      end

      // reset during RUN with a read pending
      start_run(4);
      send(1, 1, 1, 0);
      check("t6_busy_before", busy, 1);
      rd_en = 1'b1; rd_addr = '0;
      reset = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_rdv", rd_valid, 0);
      check("t6_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b1;
      cycle();
      check("t6_rdv_after", rd_valid, 1);
      rd_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end
endmodule

// File: doc/shot_avg_acc.md
Name: shot_avg_acc

Overview:
- Sits directly downstream of the per-channel readout mixer/accumulators in dsp.
- Takes each integrated (accx, accy) result as it is produced and sums it into a per-measurement-index running total across repeated shots.
- Host reads averaged sums instead of raw per-shot accumulator dumps.
- One instance per readout channel; read side is polled by the register/BRAM readout path.

Parameters:
- DATAWIDTH, 32, signed width of in_x/in_y (matches accumulator output halves)
- SUMWIDTH, 48, signed width of each stored sum
- ADDRWIDTH, 10, log2 of measurement slots per shot (1024)
- SHOTCNTWIDTH, 16, width of shot counter and nshots

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low (asserted when 0)
- start  in  1  one-cycle pulse: abort any run, clear sums, arm for nshots
- nshots  in  SHOTCNTWIDTH  number of shots to sum; sampled on start
- shot_end  in  1  one-cycle pulse marking end of a shot
- in_valid  in  1  in_x/in_y valid this cycle
- in_x  in  DATAWIDTH  signed I accumulator result
- in_y  in  DATAWIDTH  signed Q accumulator result
- rd_en  in  1  read request
- rd_addr  in  ADDRWIDTH  measurement slot to read
- rd_valid  out  1  rd_x/rd_y valid
- rd_x  out  SUMWIDTH  summed I for slot
- rd_y  out  SUMWIDTH  summed Q for slot
- busy  out  1  high in CLEAR or RUN
- done  out  1  high in DONE
- overflow  out  1  sticky: slot overrun or sum saturation since last start
- meas_count  out  ADDRWIDTH+1  number of slots written in the most recent completed shot

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; sum memory contents undefined.
- States:
  - IDLE -> CLEAR on start.
  - CLEAR writes zero to slots 0..2^ADDRWIDTH-1, one per cycle (2^ADDRWIDTH cycles), then enters RUN; if nshots==0 it enters DONE instead.
  - RUN -> DONE when shot counter reaches nshots and the pipeline has drained.
  - DONE -> CLEAR on start.
  - start in any state (CLEAR/RUN included) restarts CLEAR with a fresh nshots, clears overflow, shot counter, slot index and in-flight pipeline writes.
- RUN data path:
  - Slot index idx starts at 0 each shot; each accepted in_valid targets slot idx, then idx++.
  - in_valid outside RUN is ignored.
  - in_valid with idx == 2^ADDRWIDTH is dropped and sets overflow.
- Read-modify-write pipeline, 3 stages:
  - S0 issues memory read.
  - S1 receives read data (1-cycle BRAM latency).
  - S2 adds sign-extended input and writes back.
  - A write is committed 3 cycles after in_valid.
  - Accepts one sample per cycle with no stall.
  - Forwarding required: if S0 address equals the address being written in S1 or S2, use the forwarded sum, not memory data. This covers one-slot shots with back-to-back shot_end.
- Arithmetic: sum + sign_extend(in) saturates to signed SUMWIDTH limits (max 2^(SUMWIDTH-1)-1, min -2^(SUMWIDTH-1)); saturation sets overflow. I and Q are independent.
- shot_end in RUN:
  - shotcnt++; meas_count <= idx; idx <= 0 next cycle.
  - in_valid coinciding with shot_end belongs to the ending shot and is counted in meas_count.
- Completion: when shotcnt reaches nshots, further in_valid/shot_end are ignored. done asserts exactly 3 cycles after that shot_end, once the final write has retired.
- Read port:
  - Serviced only in IDLE and DONE.
  - rd_valid asserts 1 cycle after rd_en with rd_x/rd_y for rd_addr; one read per cycle.
  - rd_en in CLEAR/RUN is ignored (rd_valid stays 0).
- busy = CLEAR|RUN; done = DONE; overflow sticky until next start or reset.

Test Plan:
- Reset then start, nshots=4; each shot 3 valids in_x=10,-20,30, in_y=1,2,3, then shot_end -> done 3 cycles after 4th shot_end; read slots 0..2 -> x=40,-80,120, y=4,8,12; meas_count=3; overflow=0.
- One slot per shot, nshots=5, in_valid and shot_end in the same cycle on 5 consecutive cycles with in_x=7 -> slot0 x=35 (forwarding exercised); done asserted.
- SUMWIDTH=34, in_x=0x7FFFFFFF repeated 8 shots to slot 0 -> rd_x saturates at 2^33-1; overflow=1.
- 1025 valids in one shot with ADDRWIDTH=10 -> 1025th dropped, overflow=1, meas_count=1024, slot 1023 holds only its own value.
- start mid-RUN after 2 of 4 shots, new nshots=1, one valid in_x=5 -> after CLEAR all slots 0 except slot0=5; overflow cleared.
- reset deasserted mid-RUN with rd_en high -> state IDLE immediately, busy=done=rd_valid=overflow=0; next rd_en gives rd_valid 1 cycle later.
